ifmap_dbuf_ctrl: RTL and testbench
==================================

# ifmap_dbuf_ctrl

Controller for the input-feature-map double buffer. Each cycle it decides whether the input stream may write one word into the write bank and whether the array feeder may read one word from the read bank. It generates the step enables for the sequential write address generator and the ifmap read address generator, and it swaps the two banks at tile boundaries. It runs one layer of `NUM_TILES` tiles per `start`, then pulses `done`.

## Interface
- `BANK_ADDR_WIDTH`, default 8: width of the bank addresses; `WR_COUNT` must not exceed 2^`BANK_ADDR_WIDTH`.
- `COUNT_WIDTH`, default 16: width of `WR_COUNT` and `RD_COUNT`. `RD_COUNT` exceeds the bank depth because overlapping windows re-read words.
- `TILE_WIDTH`, default 16: width of `NUM_TILES`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `config_en` in 1: latch `config_data` when the block is in IDLE.
- `config_data` in 2*`COUNT_WIDTH`+`TILE_WIDTH`: packed as {`WR_COUNT`, `RD_COUNT`, `NUM_TILES`}, MSB first.
- `start` in 1: begin a layer; honoured in IDLE only.
- `in_valid` in 1: input stream has a word.
- `in_ready` out 1: write bank can accept a word.
- `wadr_en` out 1: bank write enable and write-generator step; equals `in_valid` & `in_ready`.
- `rd_ready` in 1: feeder accepts a read word this cycle.
- `radr_en` out 1: bank read enable and read-generator step.
- `wbank` out 1: bank index currently written.
- `rbank` out 1: bank index currently read; always equals ~`wbank`.
- `swap` out 1: one-cycle pulse; address generators restart their tile sequence on it.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at layer end.

## Operation
- States:
  - IDLE: `start` → RUN, clears all counters and flags.
  - RUN: moves to IDLE on the edge after `done`.
- Internal registers:
  - `wr_cnt`, `rd_cnt`: COUNT_WIDTH-bit word counters.
  - `tiles_written`, `tiles_read`: TILE_WIDTH-bit tile counters.
  - `wr_full`: write bank holds a complete tile.
  - `rd_valid`: read bank holds an unread tile.
- `in_ready` = RUN & !`wr_full` & (`tiles_written` < `NUM_TILES`).
- Write tile completion: on `wadr_en` with `wr_cnt` == `WR_COUNT`-1, `wr_cnt` clears, `wr_full` sets and `tiles_written` increments. Otherwise `wadr_en` increments `wr_cnt`.
- `radr_en` = RUN & `rd_valid` & `rd_ready`.
- Read tile completion: on `radr_en` with `rd_cnt` == `RD_COUNT`-1, `rd_cnt` clears, `rd_valid` clears and `tiles_read` increments.
- `swap` = RUN & `wr_full` & !`rd_valid` (combinational). At the next edge:
  - `wbank` toggles;
  - `wr_full` clears;
  - `rd_valid` sets.
- `done` = RUN & (`tiles_read` == `NUM_TILES`) (combinational).
- `NUM_TILES` = 0: `done` pulses in the first RUN cycle, with no traffic.
- `WR_COUNT` or `RD_COUNT` = 0 is treated as 1.
- `config_en` and `start` are ignored in RUN.
- Configuration registers keep their values across layers and are zeroed only by reset.

## Timing
- Reset values:
  - `state` = IDLE, all counters and flags 0;
  - `wbank` = 0, `rbank` = 1;
  - `in_ready`, `wadr_en`, `radr_en`, `swap`, `busy`, `done` all 0.
- Reset asserted mid-layer aborts the layer immediately; no `done` is produced.
- `start` sampled at edge N: RUN from cycle N+1, first `wadr_en` possible in cycle N+1.
- A bank swap costs exactly one cycle: `swap` is high in cycle K, and the first read of the new tile is possible in cycle K+1.
- The write side runs concurrently with the read side on the opposite bank.
- A full write bank stalls `in_ready` until the swap.
- A read completion and a write completion on the same edge produce `swap` in the next cycle.
- The feeder sees no `radr_en` between the last read of a tile and the cycle after `swap`. The minimum gap is 1 cycle.

## Structure
- Shared package `ifmap_ctrl_pkg` holds:
  - the state enum {IDLE, RUN};
  - the `config_data` field widths and offsets.
- One sub-module, `step_counter`: a parameterised-width counter with clear, enable and a terminal flag (count == limit-1). Instantiated for `wr_cnt` and `rd_cnt`.
- Tile counters and flags stay inline.

## Test plan
- `WR_COUNT`=4, `RD_COUNT`=6, `NUM_TILES`=3, `in_valid`=`rd_ready`=1, `start` at edge 0:
  - `wadr_en` in cycles 1-4, 6-9 and 13-16;
  - `swap` in cycles 5, 12 and 19;
  - `radr_en` in cycles 6-11, 13-18 and 20-25;
  - `done` in cycle 26; `busy` low from cycle 27;
  - totals: 12 writes, 18 reads, `wbank` ends at 1.
- Same config with `rd_ready` low in cycles 8-20: `in_ready` stays low after tile 2 fills. No second `swap` occurs until 6 reads complete. Read and write totals are unchanged.
- `NUM_TILES`=0: `done` in cycle 1, with zero `wadr_en` and zero `radr_en`.
- `start` and `config_en` pulsed in RUN: no effect; the original sequence completes unchanged.
- `rst_n` low at cycle 8 of scenario 1: all outputs return to their reset values in cycle 9. A new `start` then reproduces the scenario-1 timeline.
- `WR_COUNT`=0, `RD_COUNT`=1, `NUM_TILES`=2: behaves as 1 write and 1 read per tile; 2 `swap` pulses, then `done`.

Source files
------------

// File: rtl/ifmap_dbuf_ctrl_pkg.sv
// Shared types and config_data field layout for the ifmap double-buffer controller.
package ifmap_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_BANK_ADDR_WIDTH = 8;
    localparam int DEF_COUNT_WIDTH     = 16;
    localparam int DEF_TILE_WIDTH      = 16;

    // config_data = {WR_COUNT, RD_COUNT, NUM_TILES}, MSB first
    function automatic int cfg_width(int count_width, int tile_width);
        return 2 * count_width + tile_width;
    endfunction

    function automatic int num_tiles_lsb();
        return 0;
    endfunction

    function automatic int rd_count_lsb(int tile_width);
        return tile_width;
    endfunction

    function automatic int wr_count_lsb(int count_width, int tile_width);
        return count_width + tile_width;
    endfunction

endpackage

// File: rtl/ifmap_dbuf_ctrl_if.sv
// Handshake, configuration and status bundle of the ifmap double-buffer controller.
interface ifmap_dbuf_if
    import ifmap_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int TILE_WIDTH  = DEF_TILE_WIDTH
);
    localparam int CFG_WIDTH = cfg_width(COUNT_WIDTH, TILE_WIDTH);

    logic                 config_en;
    logic [CFG_WIDTH-1:0] config_data;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 wadr_en;
    logic                 rd_ready;
    logic                 radr_en;
    logic                 wbank;
    logic                 rbank;
    logic                 swap;
    logic                 busy;
    logic                 done;

    modport master (
        output config_en, config_data, start, in_valid, rd_ready,
        input  in_ready, wadr_en, radr_en, wbank, rbank, swap, busy, done
    );

    modport slave (
        input  config_en, config_data, start, in_valid, rd_ready,
        output in_ready, wadr_en, radr_en, wbank, rbank, swap, busy, done
    );

endinterface

// File: rtl/ifmap_dbuf_ctrl_step_counter.sv
// Word counter with synchronous clear, step enable and wrap at limit-1.
module step_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             last
);
    logic [WIDTH-1:0] count;

    assign last = (count == limit - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || (en && last)) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ifmap_dbuf_ctrl.sv
// Ifmap double-buffer controller: write/read step enables, bank swap and layer sequencing.
//   state | meaning
//   IDLE  | waiting for start; config_en latches config_data
//   RUN   | streaming NUM_TILES tiles through the two banks; leaves on done
module ifmap_dbuf_ctrl
    import ifmap_ctrl_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
    parameter int TILE_WIDTH      = DEF_TILE_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    ifmap_dbuf_if.slave bus
);
    localparam int CW     = COUNT_WIDTH;
    localparam int TW     = TILE_WIDTH;
    localparam int WR_LSB = wr_count_lsb(CW, TW);
    localparam int RD_LSB = rd_count_lsb(TW);
    localparam int NT_LSB = num_tiles_lsb();

    if (BANK_ADDR_WIDTH < 1) begin : g_bad_bank_addr_width
        $error("BANK_ADDR_WIDTH must be at least 1");
    end

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cfg_wr_count;
    logic [CW-1:0]  cfg_rd_count;
    logic [TW-1:0]  cfg_num_tiles;
    logic [CW-1:0]  wr_limit;
    logic [CW-1:0]  rd_limit;
    logic [TW-1:0]  tiles_written;
    logic [TW-1:0]  tiles_read;
    logic           wr_full;
    logic           rd_valid;
    logic           wbank_q;
    logic           wr_last;
    logic           rd_last;
    logic           run;
    logic           clr;
    logic           in_ready;
    logic           wadr_en;
    logic           radr_en;
    logic           swap;
    logic           done;

    always_comb begin
        run      = (state == RUN);
        clr      = (state == IDLE) && bus.start;
        in_ready = run && !wr_full && (tiles_written < cfg_num_tiles);
        wadr_en  = bus.in_valid && in_ready;
        radr_en  = run && rd_valid && bus.rd_ready;
        swap     = run && wr_full && !rd_valid;
        done     = run && (tiles_read == cfg_num_tiles);
        // a zero count still moves one word per tile
        wr_limit = (cfg_wr_count == '0) ? CW'(1) : cfg_wr_count;
        rd_limit = (cfg_rd_count == '0) ? CW'(1) : cfg_rd_count;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (done)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_wr_count  <= '0;
            cfg_rd_count  <= '0;
            cfg_num_tiles <= '0;
        end else if ((state == IDLE) && bus.config_en) begin
            cfg_wr_count  <= bus.config_data[WR_LSB +: CW];
            cfg_rd_count  <= bus.config_data[RD_LSB +: CW];
            cfg_num_tiles <= bus.config_data[NT_LSB +: TW];
        end
    end

    // swap needs wr_full & !rd_valid, so it never coincides with a tile completion
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            tiles_written <= '0;
            tiles_read    <= '0;
            wr_full       <= 1'b0;
            rd_valid      <= 1'b0;
            wbank_q       <= 1'b0;
        end else if (run) begin
            if (swap) begin
                wr_full  <= 1'b0;
                rd_valid <= 1'b1;
                wbank_q  <= ~wbank_q;
            end
            if (wadr_en && wr_last) begin
                wr_full       <= 1'b1;
                tiles_written <= tiles_written + TW'(1);
            end
            if (radr_en && rd_last) begin
                rd_valid   <= 1'b0;
                tiles_read <= tiles_read + TW'(1);
            end
        end
    end

    step_counter #(.WIDTH(CW)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (wadr_en),
        .limit (wr_limit),
        .last  (wr_last)
    );

    step_counter #(.WIDTH(CW)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (radr_en),
        .limit (rd_limit),
        .last  (rd_last)
    );

    assign bus.in_ready = in_ready;
    assign bus.wadr_en  = wadr_en;
    assign bus.radr_en  = radr_en;
    assign bus.wbank    = wbank_q;
    assign bus.rbank    = ~wbank_q;
    assign bus.swap     = swap;
    assign bus.busy     = run;
    assign bus.done     = done;

endmodule

// File: tb/tb_ifmap_dbuf_ctrl.sv
// Scoreboard bench: expected event cycles are queued per layer and popped as the DUT fires them.
module tb_ifmap_dbuf_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifmap_dbuf_if #(.COUNT_WIDTH(16), .TILE_WIDTH(16)) bus ();

    ifmap_dbuf_ctrl #(
        .BANK_ADDR_WIDTH (8),
        .COUNT_WIDTH     (16),
        .TILE_WIDTH      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int qw[$];
    int qr[$];
    int qs[$];
    int qd[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    // kind: 0 wadr_en, 1 radr_en, 2 swap, 3 done
    task automatic expect_range(input int kind, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            case (kind)
                0: qw.push_back(c);
                1: qr.push_back(c);
                2: qs.push_back(c);
                default: qd.push_back(c);
            endcase
        end
    endtask

    task automatic pop_check(input string name, input int kind, input int cyc);
        int e;
        e = -1;
        case (kind)
            0: if (qw.size() > 0) e = qw.pop_front();
            1: if (qr.size() > 0) e = qr.pop_front();
            2: if (qs.size() > 0) e = qs.pop_front();
            default: if (qd.size() > 0) e = qd.pop_front();
        endcase
        case (kind)
            0: check({name, "_wadr_en_cycle"}, cyc, e);
            1: check({name, "_radr_en_cycle"}, cyc, e);
            2: check({name, "_swap_cycle"}, cyc, e);
            default: check({name, "_done_cycle"}, cyc, e);
        endcase
    endtask

    task automatic configure(input int wr, input int rd, input int nt);
        bus.config_data = {16'(wr), 16'(rd), 16'(nt)};
        bus.config_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.config_en   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, bus.in_ready, 0);
        check({name, "_wadr_en"},  bus.wadr_en,  0);
        check({name, "_radr_en"},  bus.radr_en,  0);
        check({name, "_swap"},     bus.swap,     0);
        check({name, "_busy"},     bus.busy,     0);
        check({name, "_done"},     bus.done,     0);
        check({name, "_wbank"},    bus.wbank,    0);
        check({name, "_rbank"},    bus.rbank,    1);
    endtask

    // rd_ready low in [rd_lo,rd_hi]; start+config_en pulsed at junk_a/junk_b;
    // rst_n low in rst_cyc; in_ready must stay low in [ir_lo,ir_hi]
    task automatic run_layer(input string name, input int rd_lo, input int rd_hi,
                             input int junk_a, input int junk_b, input int rst_cyc,
                             input int ir_lo, input int ir_hi,
                             input int exp_w, input int exp_r, input int exp_wb);
        int k;
        int done_cyc;
        int tot_w;
        int tot_r;
        int bad_rel;
        int ir_hits;
        bit junk;
        done_cyc = 0;
        tot_w = 0;
        tot_r = 0;
        bad_rel = 0;
        ir_hits = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (k = 1; k <= 150; k++) begin
            junk = (k == junk_a) || (k == junk_b);
            bus.rd_ready  = !((k >= rd_lo) && (k <= rd_hi));
            bus.start     = junk;
            bus.config_en = junk;
            if (junk) bus.config_data = {16'd1, 16'd1, 16'd1};
            rst_n = (k != rst_cyc);
            @(negedge clk);
            if ((rst_cyc != 0) && (k == rst_cyc + 1)) begin
                check_reset_outputs({name, "_after_rst"});
                break;
            end
            if (bus.wadr_en) begin pop_check(name, 0, k); tot_w++; end
            if (bus.radr_en) begin pop_check(name, 1, k); tot_r++; end
            if (bus.swap)    pop_check(name, 2, k);
            if (bus.done)    pop_check(name, 3, k);
            if ((bus.rbank == bus.wbank) || (bus.wadr_en != (bus.in_valid && bus.in_ready)))
                bad_rel++;
            if (bus.in_ready && (k >= ir_lo) && (k <= ir_hi)) ir_hits++;
            if (done_cyc != 0) begin
                check({name, "_busy_after_done"}, bus.busy, 0);
                break;
            end
            if (bus.done) done_cyc = k;
            @(posedge clk);
            #1;
        end
        bus.start     = 1'b0;
        bus.config_en = 1'b0;
        bus.rd_ready  = 1'b1;
        rst_n         = 1'b1;
        check({name, "_finished_in_budget"}, int'(k <= 150), 1);
        check({name, "_writes_left"}, qw.size(), 0);
        check({name, "_reads_left"},  qr.size(), 0);
        check({name, "_swaps_left"},  qs.size(), 0);
        check({name, "_done_left"},   qd.size(), 0);
        check({name, "_total_writes"}, tot_w, exp_w);
        check({name, "_total_reads"},  tot_r, exp_r);
        check({name, "_rbank_wadr_rel"}, bad_rel, 0);
        check({name, "_in_ready_stall"}, ir_hits, 0);
        check({name, "_wbank_end"}, bus.wbank, exp_wb);
        qw.delete();
        qr.delete();
        qs.delete();
        qd.delete();
    endtask

    task automatic expect_scenario1();
        expect_range(0, 1, 4);
        expect_range(0, 6, 9);
        expect_range(0, 13, 16);
        expect_range(2, 5, 5);
        expect_range(2, 12, 12);
        expect_range(2, 19, 19);
        expect_range(1, 6, 11);
        expect_range(1, 13, 18);
        expect_range(1, 20, 25);
        expect_range(3, 26, 26);
    endtask

    initial begin
        bus.config_en   = 1'b0;
        bus.config_data = '0;
        bus.start       = 1'b0;
        bus.in_valid    = 1'b1;
        bus.rd_ready    = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        configure(4, 6, 3);
        expect_scenario1();
        run_layer("s1", 0, -1, 0, 0, 0, 0, -1, 12, 18, 1);

        expect_range(0, 1, 4);
        expect_range(0, 6, 9);
        expect_range(0, 26, 29);
        expect_range(2, 5, 5);
        expect_range(2, 25, 25);
        expect_range(2, 32, 32);
        expect_range(1, 6, 7);
        expect_range(1, 21, 24);
        expect_range(1, 26, 31);
        expect_range(1, 33, 38);
        expect_range(3, 39, 39);
        run_layer("s2_stall", 8, 20, 0, 0, 0, 10, 25, 12, 18, 1);

        expect_scenario1();
        run_layer("s4_ignore", 0, -1, 3, 10, 0, 0, -1, 12, 18, 1);

        expect_range(0, 1, 4);
        expect_range(0, 6, 8);
        expect_range(2, 5, 5);
        expect_range(1, 6, 8);
        run_layer("s5_abort", 0, -1, 0, 0, 8, 0, -1, 7, 3, 0);

        configure(4, 6, 3);
        expect_scenario1();
        run_layer("s5_rerun", 0, -1, 0, 0, 0, 0, -1, 12, 18, 1);

        configure(4, 6, 0);
        expect_range(3, 1, 1);
        run_layer("s3_zero_tiles", 0, -1, 0, 0, 0, 0, -1, 0, 0, 0);

        configure(0, 1, 2);
        expect_range(0, 1, 1);
        expect_range(0, 3, 3);
        expect_range(2, 2, 2);
        expect_range(2, 4, 4);
        expect_range(1, 3, 3);
        expect_range(1, 5, 5);
        expect_range(3, 6, 6);
        run_layer("s6_zero_count", 0, -1, 0, 0, 0, 0, -1, 2, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
